// File: rtl/booth_multiplier_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    // Step counter must hold the value W itself, hence W+1 codes.
    function automatic int count_width(input int word_length);
        return $clog2(word_length + 1);
    endfunction

endpackage

// File: rtl/booth_multiplier_if.sv
// Start/ready handshake and operand/result bus of the Booth multiplier.
// MULT_PRODUCT_TC_EN adds the raw two's-complement Product output.
interface booth_multiplier_if #(
    parameter int WORD_LENGTH = 8
);
    logic                       start;
    logic [WORD_LENGTH-1:0]     Multiplicand;
    logic [WORD_LENGTH-1:0]     Multiplier;
    logic                       ready;
    logic                       Sign;
    logic [2*WORD_LENGTH-1:0]   Result;
`ifdef MULT_PRODUCT_TC_EN
    logic [2*WORD_LENGTH-1:0]   Product;

    modport master (
        output start, Multiplicand, Multiplier,
        input  ready, Sign, Result, Product
    );

    modport slave (
        input  start, Multiplicand, Multiplier,
        output ready, Sign, Result, Product
    );
`else
    modport master (
        output start, Multiplicand, Multiplier,
        input  ready, Sign, Result
    );

    modport slave (
        input  start, Multiplicand, Multiplier,
        output ready, Sign, Result
    );
`endif
endinterface

// File: rtl/booth_multiplier_step.sv
// One radix-2 Booth step: conditional add/subtract of M into A, then
// arithmetic shift right of the whole {A,Q,Q_1} register.
module booth_step #(
    parameter int WORD_LENGTH = 8
) (
    input  logic [WORD_LENGTH:0]   a,
    input  logic [WORD_LENGTH-1:0] q,
    input  logic                   q_1,
    input  logic [WORD_LENGTH-1:0] m,
    output logic [WORD_LENGTH:0]   a_next,
    output logic [WORD_LENGTH-1:0] q_next,
    output logic                   q_1_next
);
    localparam int W = WORD_LENGTH;

    logic [W:0] m_ext;
    logic [W:0] sum;

    always_comb begin
        m_ext = {m[W-1], m};
        case ({q[0], q_1})
            2'b01:   sum = a + m_ext;
            2'b10:   sum = a - m_ext;
            default: sum = a;
        endcase
        a_next   = {sum[W], sum[W:1]};
        q_next   = {sum[0], q[W-1:1]};
        q_1_next = q[0];
    end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier, one step per clock, sign-magnitude result.
// MULT_PRODUCT_TC_EN additionally registers the two's-complement product.
module booth_multiplier
    import booth_multiplier_pkg::*;
#(
    parameter int WORD_LENGTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    booth_multiplier_if.slave  bus
);
    localparam int W  = WORD_LENGTH;
    localparam int CW = count_width(WORD_LENGTH);

    booth_state_t   state;
    logic [W:0]     a_reg;
    logic [W-1:0]   q_reg;
    logic           q_1_reg;
    logic [W-1:0]   m_reg;
    logic [CW-1:0]  count;

    logic [W:0]     a_next;
    logic [W-1:0]   q_next;
    logic           q_1_next;
    logic [2*W-1:0] p;

    booth_step #(.WORD_LENGTH(W)) u_step (
        .a        (a_reg),
        .q        (q_reg),
        .q_1      (q_1_reg),
        .m        (m_reg),
        .a_next   (a_next),
        .q_next   (q_next),
        .q_1_next (q_1_next)
    );

    // A[W] only guards the M = -2^(W-1) subtraction; the product fits in 2W bits.
    assign p = {a_reg[W-1:0], q_reg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            a_reg      <= '0;
            q_reg      <= '0;
            q_1_reg    <= 1'b0;
            m_reg      <= '0;
            count      <= '0;
            bus.ready  <= 1'b0;
            bus.Sign   <= 1'b0;
            bus.Result <= '0;
`ifdef MULT_PRODUCT_TC_EN
            bus.Product <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.ready <= 1'b0;
                    if (bus.start) begin
                        m_reg   <= bus.Multiplicand;
                        q_reg   <= bus.Multiplier;
                        a_reg   <= '0;
                        q_1_reg <= 1'b0;
                        count   <= '0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    bus.ready <= 1'b0;
                    a_reg     <= a_next;
                    q_reg     <= q_next;
                    q_1_reg   <= q_1_next;
                    count     <= count + 1'b1;
                    if (count == CW'(W - 1))
                        state <= DONE;
                end
                DONE: begin
                    bus.ready  <= 1'b1;
                    bus.Sign   <= p[2*W-1];
                    bus.Result <= p[2*W-1] ? -p : p;
`ifdef MULT_PRODUCT_TC_EN
                    bus.Product <= p;
`endif
                    state <= IDLE;
                end
                default: begin
                    bus.ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Bench for booth_multiplier: random and corner operands checked every cycle
// against a plain-arithmetic model of product, sign, magnitude and ready timing.
module tb_booth_multiplier;
    localparam int W = 8;

    typedef struct {
        int             due;
        logic           sign;
        logic [2*W-1:0] result;
        logic [2*W-1:0] product;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    booth_multiplier_if #(.WORD_LENGTH(W)) bus ();

    booth_multiplier #(.WORD_LENGTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t           expq[$];
    logic           hold_sign    = 1'b0;
    logic [2*W-1:0] hold_result  = '0;
    logic [2*W-1:0] hold_product = '0;
    logic           exp_rdy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   p;
        int   mag;
        p         = a * b;
        mag       = (p < 0) ? -p : p;
        e.due     = 0;
        e.sign    = (p < 0);
        e.result  = mag[2*W-1:0];
        e.product = p[2*W-1:0];
        return e;
    endfunction

    // Outputs must always equal the most recently delivered result (or zero after reset).
    always @(negedge clk) begin
        exp_rdy = (expq.size() > 0) && (expq[0].due == cyc);
        chk("ready", 32'(bus.ready), 32'(exp_rdy));
        if (exp_rdy) begin
            hold_sign    = expq[0].sign;
            hold_result  = expq[0].result;
            hold_product = expq[0].product;
            void'(expq.pop_front());
        end
        chk("sign", 32'(bus.Sign), 32'(hold_sign));
        chk("result", 32'(bus.Result), 32'(hold_result));
`ifdef MULT_PRODUCT_TC_EN
        chk("product", 32'(bus.Product), 32'(hold_product));
`endif
    end

    // Returns at the negedge on which ready must be visible.
    task automatic issue(input int a, input int b, input bit junk);
        exp_t e;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.Multiplicand = a[W-1:0];
        bus.Multiplier   = b[W-1:0];
        e     = model(a, b);
        e.due = cyc + W + 2;
        expq.push_back(e);
        @(negedge clk);
        bus.start        = 1'b0;
        bus.Multiplicand = W'($urandom);
        bus.Multiplier   = W'($urandom);
        while (cyc < e.due) begin
            @(negedge clk);
            if (cyc < e.due && junk) begin
                bus.start        = 1'($urandom);
                bus.Multiplicand = W'($urandom);
                bus.Multiplier   = W'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic issue_lit(input int a, input int b, input bit junk,
                             input logic lsign, input int lres);
        issue(a, b, junk);
        chk("lit_ready", 32'(bus.ready), 32'd1);
        chk("lit_sign", 32'(bus.Sign), 32'(lsign));
        chk("lit_result", 32'(bus.Result), 32'(lres));
    endtask

    initial begin
        exp_t pin;
        int   ra;
        int   rb;

        bus.start        = 1'b0;
        bus.Multiplicand = '0;
        bus.Multiplier   = '0;

        pin = model(-128, 127);
        chk("model_pin_sign", 32'(pin.sign), 32'd1);
        chk("model_pin_result", 32'(pin.result), 32'd16256);
        chk("model_pin_product", 32'(pin.product), 32'h0000C080);
        pin = model(-128, -128);
        chk("model_pin_sq", 32'(pin.result), 32'd16384);

        repeat (3) @(negedge clk);
        #2 reset = 1'b0;

        issue_lit(3, 4, 1'b0, 1'b0, 12);
        issue_lit(-3, 4, 1'b0, 1'b1, 12);
        issue_lit(-128, -128, 1'b0, 1'b0, 16384);
        issue_lit(0, -5, 1'b0, 1'b0, 0);
        issue_lit(-1, -1, 1'b0, 1'b0, 1);
        issue_lit(-128, 127, 1'b0, 1'b1, 16256);
        issue_lit(127, -128, 1'b1, 1'b1, 16256);
        issue_lit(7, 9, 1'b1, 1'b0, 63);
        issue_lit(-5, 0, 1'b0, 1'b0, 0);

        // Abort mid-computation: no ready may follow and outputs must clear.
        @(negedge clk);
        bus.start        = 1'b1;
        bus.Multiplicand = 8'd5;
        bus.Multiplier   = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        expq.delete();
        hold_sign    = 1'b0;
        hold_result  = '0;
        hold_product = '0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        repeat (12) @(negedge clk);
        issue_lit(6, -7, 1'b0, 1'b1, 42);

        for (int i = 0; i < 300; i++) begin
            ra = int'($urandom_range(0, 255)) - 128;
            rb = int'($urandom_range(0, 255)) - 128;
            issue(ra, rb, 1'($urandom));
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
